// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
// Module  : mdu_sched
// Brief   : Multiply/divide scheduler with HI/LO registers and pipeline stall.
// Revision: 1.0 - initial release
// ============================================================================
module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_uses_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;
    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;

    logic        w_md_op;
    logic        w_is_mul;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_den_s;
    logic [31:0] w_den_u;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_md_op  = (op >= c_op_mult) && (op <= c_op_divu);
    assign w_is_mul = (op == c_op_mult) || (op == c_op_multu);

    // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply
    // equal to the two's-complement signed product.
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide on magnitudes; the divisor is forced to 1 on divide-by-zero
    // since that result is never committed. 0x80000000 / -1 falls out naturally.
    assign w_mag_a  = a[31] ? (32'd0 - a) : a;
    assign w_mag_b  = b[31] ? (32'd0 - b) : b;
    assign w_den_s  = (b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_den_u  = (b == 32'd0) ? 32'd1 : b;
    assign w_sq_mag = w_mag_a / w_den_s;
    assign w_sr_mag = w_mag_a % w_den_s;
    assign w_sq     = (a[31] ^ b[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
    assign w_uq     = a / w_den_u;
    assign w_ur     = a % w_den_u;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (op)
            c_op_mult:  {w_res_hi, w_res_lo} = w_prod_s;
            c_op_multu: {w_res_hi, w_res_lo} = w_prod_u;
            c_op_div: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
            end
            c_op_divu: begin
                w_res_hi = w_ur;
                w_res_lo = w_uq;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_md_op) begin
                            r_state   <= S_RUN;
                            r_count   <= w_is_mul ? c_mult_cnt : c_div_cnt;
                            r_pend_hi <= w_res_hi;
                            r_pend_lo <= w_res_lo;
                            r_pend_wr <= w_is_mul || (b != 32'd0);
                        end else if (op == c_op_mthi) begin
                            r_hi <= a;
                        end else if (op == c_op_mtlo) begin
                            r_lo <= a;
                        end
                    end
                end
                S_RUN: begin
                    // Starts in RUN are ignored; the stall keeps them out of legal code.
                    if (r_count == 4'd1) begin
                        r_count <= 4'd0;
                        r_state <= S_IDLE;
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (r_state == S_RUN);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign stall = d_uses_md & ((start & w_md_op) | busy);

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// Testbench for mdu_sched: random and directed commands, scoreboard checked
// against an arithmetic reference model when each operation completes.
module tb_mdu_sched;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_uses_md;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    mdu_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .d_uses_md (d_uses_md),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          n;
    } item_t;

    item_t       sbq[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference results {hi, lo}, straight from the arithmetic definitions.
    function automatic logic [63:0] ref_md(logic [2:0] o, logic [31:0] x, logic [31:0] y,
                                           logic [31:0] cur_hi, logic [31:0] cur_lo);
        longint          sp;
        longint unsigned up;
        int              sx;
        int              sy;
        sx = int'(x);
        sy = int'(y);
        case (o)
            3'd1: begin
                sp = longint'(sx) * longint'(sy);
                return sp;
            end
            3'd2: begin
                up = longint'(x) * longint'(y);
                return up;
            end
            3'd3: begin
                if (y == 32'd0) return {cur_hi, cur_lo};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            3'd4: begin
                if (y == 32'd0) return {cur_hi, cur_lo};
                return {x % y, x / y};
            end
            default: return {cur_hi, cur_lo};
        endcase
    endfunction

    // Monitor: every fall of busy retires the oldest expected operation.
    initial begin
        int   bcnt;
        logic pb;
        item_t it;
        bcnt = 0;
        pb   = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) begin
                bcnt++;
                if (sbq.size() == 0) begin
                    check("busy_without_cmd", {63'd0, busy}, 64'd0);
                end else begin
                    check("hold_hi", {32'd0, hi}, {32'd0, sbq[0].old_hi});
                    check("hold_lo", {32'd0, lo}, {32'd0, sbq[0].old_lo});
                end
            end else if (pb) begin
                if (sbq.size() == 0) begin
                    check("done_without_cmd", 64'd1, 64'd0);
                end else begin
                    it = sbq.pop_front();
                    check("result_hi", {32'd0, hi}, {32'd0, it.hi});
                    check("result_lo", {32'd0, lo}, {32'd0, it.lo});
                    check("busy_cycles", 64'(bcnt), 64'(it.n));
                end
                bcnt = 0;
            end
            pb = busy;
        end
    end

    // Called at a negedge; returns at a point where busy=0 and start=0.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input bit hold_d);
        logic [63:0] r;
        item_t       it;
        bit          md;
        int          guard;
        md        = (o >= 3'd1 && o <= 3'd4);
        start     = 1'b1;
        op        = o;
        a         = av;
        b         = bv;
        d_uses_md = hold_d ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        check("stall_start", {63'd0, stall}, {63'd0, d_uses_md & md});
        if (md) begin
            r         = ref_md(o, av, bv, m_hi, m_lo);
            it.old_hi = m_hi;
            it.old_lo = m_lo;
            it.hi     = r[63:32];
            it.lo     = r[31:0];
            it.n      = (o <= 3'd2) ? MULT_N : DIV_N;
            sbq.push_back(it);
            m_hi = it.hi;
            m_lo = it.lo;
        end else if (o == 3'd5) begin
            m_hi = av;
        end else if (o == 3'd6) begin
            m_lo = av;
        end
        @(negedge clk);
        start = 1'b0;
        if (!md) begin
            #1;
            check("idle_busy", {63'd0, busy}, 64'd0);
            check("move_hi", {32'd0, hi}, {32'd0, m_hi});
            check("move_lo", {32'd0, lo}, {32'd0, m_lo});
        end else begin
            guard = 0;
            while (busy && guard < 40) begin
                if (!hold_d) d_uses_md = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0 || (hold_d && guard == 1)) begin
                    start = 1'b1;
                    op    = 3'($urandom_range(0, 7));
                    a     = $urandom;
                    b     = $urandom;
                end
                #1;
                check("stall_busy", {63'd0, stall}, {63'd0, d_uses_md});
                @(negedge clk);
                start = 1'b0;
                guard++;
            end
            if (busy) check("busy_timeout", {63'd0, busy}, 64'd0);
            #1;
            check("stall_after", {63'd0, stall}, 64'd0);
        end
    endtask

    task automatic abort_div(input logic [31:0] av, input logic [31:0] bv);
        item_t it;
        start     = 1'b1;
        op        = 3'd3;
        a         = av;
        b         = bv;
        d_uses_md = 1'b0;
        #1;
        it.old_hi = m_hi;
        it.old_lo = m_lo;
        it.hi     = 32'd0;
        it.lo     = 32'd0;
        it.n      = 3;
        sbq.push_back(it);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        repeat (DIV_N + 2) @(negedge clk);
        check("late_busy", {63'd0, busy}, 64'd0);
        check("late_hi", {32'd0, hi}, 64'd0);
        check("late_lo", {32'd0, lo}, 64'd0);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] av;
        logic [31:0] bv;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 3'd0;
        a         = 32'd0;
        b         = 32'd0;
        d_uses_md = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_stall", {63'd0, stall}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        d_uses_md = 1'b1;
        #1;
        check("idle_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
        issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(3'd6, 32'h0000_1234, 32'd0, 1'b0);
        issue(3'd5, 32'h0000_5678, 32'd0, 1'b0);
        issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(3'd5, 32'hA5A5_0001, 32'd0, 1'b0);
        issue(3'd0, 32'h1111_1111, 32'd1, 1'b1);
        issue(3'd7, 32'h2222_2222, 32'd1, 1'b1);
        abort_div(32'd100, 32'd7);

        for (int i = 0; i < 150; i++) begin
            o  = 3'($urandom_range(0, 7));
            av = $urandom;
            case ($urandom_range(0, 7))
                0:       bv = 32'd0;
                1:       bv = 32'($urandom_range(1, 9));
                2:       bv = 32'hFFFF_FFFF;
                default: bv = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) begin
                av = 32'h8000_0000;
                bv = 32'hFFFF_FFFF;
            end
            issue(o, av, bv, $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        check("sb_drain", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide scheduler for the five-stage pipeline: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the E stage and holds the HI/LO architectural registers. It models fixed multi-cycle latency with an internal countdown. While a D-stage instruction needs the unit and the unit is starting or busy, it drives the stall that freezes the F/D register, holds PC, and inserts a bubble into D/E. It sits beside the ALU in E, and its HI/LO outputs feed the E-stage result mux for MFHI/MFLO.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1–15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1–15)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  E-stage instruction is an MD command this cycle
- op  in  3  command: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 0 and 7 are no-op
- a  in  32  rs operand (forwarded value)
- b  in  32  rt operand (forwarded value)
- d_uses_md  in  1  D-stage instruction is any of MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
- busy  out  1  multi-cycle operation in progress
- hi  out  32  HI register
- lo  out  32  LO register
- stall  out  1  freeze PC and F/D, bubble D/E

## Operation
- State machine: IDLE, RUN.
  - IDLE → RUN when start=1 with op 1–4. On that edge:
    - load count with MULT_CYCLES (op 1, 2) or DIV_CYCLES (op 3, 4);
    - latch the full result into pending_hi/pending_lo.
  - RUN: count decrements each edge. When count=1, the next edge writes hi/lo from pending, clears count, and goes to IDLE.
- Results:
  - MULT: signed 64-bit product, hi = [63:32], lo = [31:0].
  - MULTU: the same, unsigned.
  - DIV: lo = quotient truncated toward zero, hi = remainder with the sign of a. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned quotient and remainder.
  - b=0 for DIV/DIVU: the full DIV_CYCLES busy period runs, then hi/lo are left unchanged.
- MTHI/MTLO (op 5/6) with start=1 in IDLE: hi (or lo) := a at the next edge. No busy.
- start=1 in RUN is ignored, because stall prevents it in legal programs; pending and count are unaffected.
- No-op opcodes with start=1 do nothing.
- busy = (state == RUN).
- stall = d_uses_md & ((start & op in 1–4) | busy). Combinational.
- A pending result is never visible before completion. MFHI/MFLO in E during RUN cannot occur because the stall holds them in D.

## Timing
- Reset values:
  - hi, lo, pending_hi, pending_lo = 0;
  - count = 0, state = IDLE;
  - busy = 0; stall = 0 whenever d_uses_md=0.
- reset=1 in RUN aborts the operation: the pending result is discarded, hi/lo = 0 after that edge, and busy = 0.
- Latency for a command sampled with start=1 at edge E0:
  - busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), from E0 until edge E0+N;
  - hi/lo take their new values at edge E0+N, in the same cycle busy falls.
- Back-to-back: a new start is accepted in the first cycle busy=0.
- MTHI/MTLO in the cycle right after completion overrides the completed value at the next edge.
- stall response is zero-cycle, the same cycle as start or busy. stall is never asserted on account of an MTHI/MTLO start.
- count is 4 bits wide, so no wrap occurs within the legal parameter range.

## Test plan
- After reset, MULT a=0xFFFFFFFE (-2), b=3, start one cycle:
  - busy=1 for 5 cycles, hi/lo unchanged during that time;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Same operands with MULTU: hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
- DIV a=-7, b=2: busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU with b=0 after MTLO a=0x1234 and MTHI a=0x5678:
  - busy still runs 10 cycles;
  - afterwards hi=0x5678, lo=0x1234.
- d_uses_md=1 held throughout a MULT:
  - stall=1 in the start cycle and all 5 busy cycles, and 0 the cycle after;
  - a second start during busy leaves the results from the first MULT intact.
- Reset asserted on the third busy cycle of DIV: next cycle busy=0, hi=lo=0, and no late write occurs.
